// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//   Quadrature encoder front end. Raw A/B pins are brought into the clk
//   domain with a two-flop synchronizer. They are debounced on strobe ticks
//   only, then decoded from Gray-code transitions into a signed position
//   count.
//
// Parameters
//   WIDTH  position counter width in bits
//   DEB    consecutive agreeing strobe samples needed to accept a level (>= 2)
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   pin_a   in   raw encoder channel A (asynchronous)
//   pin_b   in   raw encoder channel B (asynchronous)
//   strobe  in   1-cycle sample tick
//   clear   in   synchronous clear of count and error
//   count   out  position counter, two's complement, wraps modulo 2^WIDTH
//   step    out  1-cycle pulse per accepted count change
//   dir     out  direction of the last accepted step (1 = up)
//   error   out  sticky flag for a transition where both channels changed
// ---------------------------------------------------------------------------
module quad_decoder #(
   parameter int WIDTH = 16,
   parameter int DEB   = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pin_a,
   input  logic                    pin_b,
   input  logic                    strobe,
   input  logic                    clear,
   output logic signed [WIDTH-1:0] count,
   output logic                    step,
   output logic                    dir,
   output logic                    error
);

   localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

   // Position of an AB code within the up-counting cycle 00->10->11->01.
   function automatic logic [1:0] phase(input logic [1:0] ab);
      logic [1:0] p;
      case (ab)
         2'b00:   p = 2'd0;
         2'b10:   p = 2'd1;
         2'b11:   p = 2'd2;
         default: p = 2'd3;
      endcase
      return p;
   endfunction

   // A candidate window is accepted only when every sample agrees.
   function automatic logic uniform(input logic [DEB-1:0] v);
      return (&v) | ~(|v);
   endfunction

   logic           a_p0, a_p1, b_p0, b_p1;
   logic [DEB-2:0] sh_a, sh_b;
   logic           stable_a, stable_b, primed;

   logic [DEB-1:0] cand_a, cand_b;
   logic           got_a, got_b, new_a, new_b;
   logic [1:0]     old_ab, new_ab;
   logic           both_changed, is_up, is_dn;

   // ---- debounce window: history plus the current synchronized sample ----
   assign cand_a = {sh_a, a_p1};
   assign cand_b = {sh_b, b_p1};
   assign got_a  = uniform(cand_a);
   assign got_b  = uniform(cand_b);
   assign new_a  = got_a ? a_p1 : stable_a;
   assign new_b  = got_b ? b_p1 : stable_b;

   // ---- transition classification ----
   assign old_ab       = {stable_a, stable_b};
   assign new_ab       = {new_a, new_b};
   assign both_changed = ((old_ab ^ new_ab) == 2'b11);
   assign is_up        = (phase(new_ab) == phase(old_ab) + 2'd1);
   assign is_dn        = (phase(old_ab) == phase(new_ab) + 2'd1);

   // ---- synchronizer, runs every cycle regardless of strobe ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_p0 <= 1'b0;
         a_p1 <= 1'b0;
         b_p0 <= 1'b0;
         b_p1 <= 1'b0;
      end else begin
         a_p0 <= pin_a;
         a_p1 <= a_p0;
         b_p0 <= pin_b;
         b_p1 <= b_p0;
      end
   end

   // ---- debounce, decode and count ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a     <= '0;
         sh_b     <= '0;
         stable_a <= 1'b0;
         stable_b <= 1'b0;
         primed   <= 1'b0;
         count    <= '0;
         step     <= 1'b0;
         dir      <= 1'b0;
         error    <= 1'b0;
      end else begin
         step <= 1'b0;
         if (strobe) begin
            sh_a     <= cand_a[DEB-2:0];
            sh_b     <= cand_b[DEB-2:0];
            stable_a <= new_a;
            stable_b <= new_b;
            if (!primed) begin
               // First acceptance only seeds the levels; no transition exists yet.
               if (got_a && got_b)
                  primed <= 1'b1;
            end else if (both_changed) begin
               error <= 1'b1;
            end else if (is_up) begin
               count <= count + ONE;
               dir   <= 1'b1;
               step  <= 1'b1;
            end else if (is_dn) begin
               count <= count - ONE;
               dir   <= 1'b0;
               step  <= 1'b1;
            end
         end
         // Clear overrides a coincident step for count and error only.
         if (clear) begin
            count <= '0;
            error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

   localparam int DEB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pin_a = 1'b0, pin_b = 1'b0, strobe = 1'b0, clear = 1'b0;
   logic [15:0] count;
   logic        step, dir, error;

   int errs = 0;
   int checks = 0;
   int step_cnt = 0;

   quad_decoder #(.WIDTH(16), .DEB(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .pin_a(pin_a), .pin_b(pin_b),
      .strobe(strobe), .clear(clear),
      .count(count), .step(step), .dir(dir), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // Pins reach the decoder two clocks late; a level is accepted when the
   // last DEB strobe samples agree; the AB code is mapped to its position on
   // the up cycle and the count follows the position difference.
   bit pqa[$], pqb[$], sqa[$], sqb[$];
   int pos_of [4] = '{0, 3, 1, 2};     // index {a,b}: 00,01,10,11
   logic [15:0] m_count;
   bit m_step, m_dir, m_err, m_sa, m_sb, m_primed;

   function automatic bit uni(input bit q[$]);
      foreach (q[i]) if (q[i] != q[0]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit sa, sb, ua, ub, na, nb;
      int d;
      if (!rst_n) begin
         pqa = '{0, 0};
         pqb = '{0, 0};
         sqa = {};
         sqb = {};
         for (int i = 0; i < DEB - 1; i++) begin
            sqa.push_back(1'b0);
            sqb.push_back(1'b0);
         end
         m_count = '0; m_step = 0; m_dir = 0; m_err = 0;
         m_sa = 0; m_sb = 0; m_primed = 0;
      end else begin
         sa = pqa.pop_front(); pqa.push_back(pin_a);
         sb = pqb.pop_front(); pqb.push_back(pin_b);
         m_step = 0;
         if (strobe) begin
            sqa.push_back(sa); if (sqa.size() > DEB) void'(sqa.pop_front());
            sqb.push_back(sb); if (sqb.size() > DEB) void'(sqb.pop_front());
            ua = uni(sqa); ub = uni(sqb);
            na = ua ? sqa[0] : m_sa;
            nb = ub ? sqb[0] : m_sb;
            if (!m_primed) begin
               if (ua && ub) m_primed = 1;
            end else if (na != m_sa || nb != m_sb) begin
               if (na != m_sa && nb != m_sb) m_err = 1;
               else begin
                  d = (pos_of[{na, nb}] - pos_of[{m_sa, m_sb}] + 4) % 4;
                  if (d == 1) begin m_count = m_count + 16'd1; m_dir = 1; end
                  else        begin m_count = m_count - 16'd1; m_dir = 0; end
                  m_step = 1;
               end
            end
            m_sa = na; m_sb = nb;
         end
         if (clear) begin m_count = '0; m_err = 0; end
      end
   end

   always @(negedge clk) begin
      chk("model_count", 32'(count), 32'(m_count));
      chk("model_step",  32'(step),  32'(m_step));
      chk("model_dir",   32'(dir),   32'(m_dir));
      chk("model_error", 32'(error), 32'(m_err));
      if (step) step_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic s);
      strobe = s;
      @(posedge clk); #1;
      strobe = 1'b0;
   endtask

   task automatic seg(input int n);
      for (int i = 0; i < n; i++) begin
         tick(0); tick(0); tick(0); tick(1);
      end
      tick(0); tick(0);
   endtask

   typedef struct {
      bit          clr;
      bit          a, b;
      int          n;
      logic [15:0] cnt;
      bit          d, e;
      int          steps;
   } vec_t;

   vec_t tbl [17];

   initial begin
      tbl[0]  = '{0, 1, 0, 4, 16'h0001, 1, 0, 1};
      tbl[1]  = '{0, 1, 1, 4, 16'h0002, 1, 0, 1};
      tbl[2]  = '{0, 0, 1, 4, 16'h0003, 1, 0, 1};
      tbl[3]  = '{0, 0, 0, 4, 16'h0004, 1, 0, 1};
      tbl[4]  = '{1, 0, 0, 2, 16'h0000, 1, 0, 0};
      tbl[5]  = '{0, 0, 1, 4, 16'hFFFF, 0, 0, 1};
      tbl[6]  = '{0, 1, 1, 4, 16'hFFFE, 0, 0, 1};
      tbl[7]  = '{0, 1, 0, 4, 16'hFFFD, 0, 0, 1};
      tbl[8]  = '{0, 0, 0, 4, 16'hFFFC, 0, 0, 1};
      tbl[9]  = '{0, 1, 0, 1, 16'hFFFC, 0, 0, 0};
      tbl[10] = '{0, 0, 0, 4, 16'hFFFC, 0, 0, 0};
      tbl[11] = '{0, 1, 0, 3, 16'hFFFD, 1, 0, 1};
      tbl[12] = '{0, 1, 1, 4, 16'hFFFE, 1, 0, 1};
      tbl[13] = '{0, 0, 1, 4, 16'hFFFF, 1, 0, 1};
      tbl[14] = '{0, 0, 0, 4, 16'h0000, 1, 0, 1};
      tbl[15] = '{0, 1, 1, 3, 16'h0000, 1, 1, 0};
      tbl[16] = '{1, 1, 1, 2, 16'h0000, 1, 0, 0};

      // Reset with pins idling high: priming must not count or flag.
      pin_a = 1; pin_b = 1;
      tick(0); tick(0); tick(0);
      chk("rst_count", 32'(count), 0);
      chk("rst_error", 32'(error), 0);
      rst_n = 1'b1;
      step_cnt = 0;
      seg(3);
      chk("prime11_count", 32'(count), 0);
      chk("prime11_error", 32'(error), 0);
      chk("prime11_steps", 32'(step_cnt), 0);

      // Restart from a 00 baseline for the sequences below.
      rst_n = 1'b0; pin_a = 0; pin_b = 0;
      tick(0); tick(0);
      rst_n = 1'b1;
      seg(4);
      chk("prime00_count", 32'(count), 0);

      foreach (tbl[i]) begin
         if (tbl[i].clr) begin
            clear = 1'b1; tick(0); clear = 1'b0;
         end
         step_cnt = 0;
         pin_a = tbl[i].a; pin_b = tbl[i].b;
         seg(tbl[i].n);
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("vec%0d_dir", i),   32'(dir),   32'(tbl[i].d));
         chk($sformatf("vec%0d_error", i), 32'(error), 32'(tbl[i].e));
         chk($sformatf("vec%0d_steps", i), 32'(step_cnt), 32'(tbl[i].steps));
      end

      // Reset in the middle of debouncing 11->01 discards the history.
      pin_a = 0; pin_b = 1;
      tick(0); tick(0); tick(0); tick(1);
      tick(0); tick(0); tick(0); tick(1);
      rst_n = 1'b0;
      tick(0); tick(0);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_step",  32'(step),  0);
      chk("midrst_dir",   32'(dir),   0);
      chk("midrst_error", 32'(error), 0);
      rst_n = 1'b1;
      step_cnt = 0;
      seg(4);
      chk("reprime_count", 32'(count), 0);
      chk("reprime_steps", 32'(step_cnt), 0);
      chk("reprime_error", 32'(error), 0);
      step_cnt = 0;
      pin_a = 0; pin_b = 0;
      seg(4);
      chk("afterprime_count", 32'(count), 1);
      chk("afterprime_steps", 32'(step_cnt), 1);
      chk("afterprime_dir",   32'(dir), 1);

      // Strobe held high on consecutive cycles: each cycle is a sample.
      step_cnt = 0;
      pin_a = 1; pin_b = 0;
      tick(0); tick(0);
      for (int i = 0; i < 5; i++) tick(1);
      tick(0); tick(0);
      chk("burst_count", 32'(count), 2);
      chk("burst_steps", 32'(step_cnt), 1);

      // Random pins, strobes and clears against the reference.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 24) == 0) pin_a = ~pin_a;
         if ($urandom_range(0, 24) == 0) pin_b = ~pin_b;
         clear = ($urandom_range(0, 59) == 0);
         tick($urandom_range(0, 2) == 0);
         clear = 1'b0;
      end

      tick(0); tick(0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Consumes the periodic 1-cycle sample strobe from the encoder peripheral's strobe generator.
- Takes raw quadrature encoder pins A/B, synchronizes them, and debounces them on strobe ticks only.
- Decodes Gray-code transitions into a signed position counter with step, direction and error reporting.
- Outputs feed the peripheral's register read mux.

Parameters:
- WIDTH, 16, position counter width in bits.
- DEB, 3, consecutive agreeing strobe samples needed to accept a new pin level (DEB >= 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- pin_a  input  1  raw encoder channel A, asynchronous to clk.
- pin_b  input  1  raw encoder channel B, asynchronous to clk.
- strobe  input  1  1-cycle sample tick from the strobe generator.
- clear  input  1  synchronous: zero count and error.
- count  output  WIDTH  position counter, two's complement.
- step  output  1  1-cycle pulse per accepted count change.
- dir  output  1  direction of last accepted step (1 = up).
- error  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (async, rst_n=0):
  - All registers go to 0: sync flops, shift registers, stable_a/b, primed, count, step, dir, error.
  - Reset mid-operation discards history immediately.
- Synchronizer:
  - Two flops per pin, clocked every clk cycle, independent of strobe.
  - sa/sb is the second flop output.
- Debounce (per channel, only on a clk edge where strobe=1):
  - sh <= {sh[DEB-2:0], s}. The shift register holds DEB-1 bits.
  - cand = {sh[DEB-2:0], s}. If every bit of cand equals value X, the channel's new level is X at this same edge; otherwise the level is unchanged.
  - With strobe=0, sh and the stable levels hold.
- Decode:
  - At a strobe edge, old = {stable_a, stable_b} and new = candidate accepted levels. Both channels are evaluated on the same edge.
  - primed=0: stable <= new, primed <= 1 once both channels have an accepted level. No count, step or error. This avoids a false error when pins idle high out of reset.
  - primed=1, new == old: nothing happens.
  - Increment sequence (AB): 00->10->11->01->00. count <= count+1, dir <= 1, step <= 1.
  - Reverse sequence: count <= count-1, dir <= 0, step <= 1.
  - Both bits changed: error <= 1. count, dir and step are unchanged (step 0). stable still updates to new.
- Counter:
  - Modulo 2^WIDTH wrap. 0-1 = all ones; max unsigned +1 = 0. No saturation.
- step:
  - Registered.
  - High exactly the one cycle after the accepting strobe edge.
  - Low in all other cycles.
- clear:
  - count <= 0 and error <= 0. dir is unchanged.
  - If a step occurs in the same cycle as clear, clear wins for count and error. step still pulses and dir still updates.
- Strobe held high on consecutive cycles: each cycle counts as a sample. No special casing.
- Latency, pin edge to step:
  - 2 clk for synchronization.
  - DEB agreeing strobes.
  - 1 clk for step.

Test Plan:
- Reset with pins=11, DEB=3, strobe every 4 clk. After 3 strobes: primed=1, count=0, error=0, no step pulse.
- From stable 00, drive AB 10,11,01,00, each held for 4 strobes. Result: count=4, dir=1, exactly 4 one-cycle step pulses.
- Reverse sequence from count=0. Result: count=0xFFFF after the first step, 0xFFFC after 4 steps, dir=0.
- Glitch: A toggles high for 1 strobe period (fewer than DEB samples). Result: count unchanged, no step. A high for 3 strobes: one step.
- Illegal jump 00->11, held 3 strobes. Result: error=1, count unchanged, no step. Then assert clear for 1 cycle: error=0, count=0.
- Assert rst_n low mid-debounce, then release. All outputs are 0; the next acceptance only primes and does not count.
